// File: rtl/pronoc_pkg.sv
// pronoc_pkg: shared NoC widths, header field positions and flit/channel/request types
package pronoc_pkg;
  localparam int V = 4;
  localparam int Vw = 2;
  localparam int B = 4;
  localparam int C = 4;
  localparam int Cw = 2;
  localparam int EAw = 6;
  localparam int DSTPw = 4;
  localparam int WEIGHTw = 4;
  localparam int Fpay = 32;
  localparam int FPAYw = 5;
  localparam int CRDTw = 3;
  localparam int CONGw = 2;
  localparam int PCK_SIZw = 8;
  localparam int PCK_INJ_Dw = 64;
  localparam SWA_ARBITER_TYPE = "WRRA";
  localparam int E_SRC_LSB = 0;
  localparam int E_DST_LSB = E_SRC_LSB + EAw;
  localparam int DST_P_LSB = E_DST_LSB + EAw;
  localparam int CLASS_LSB = DST_P_LSB + DSTPw;
  localparam int WEIGHT_LSB = CLASS_LSB + Cw;
  localparam int MSB_BE = WEIGHT_LSB + WEIGHTw - 1;
  localparam int HDR_MAX_DATw = Fpay - MSB_BE - 1;
  typedef struct packed {
    logic hdr_flag;
    logic tail_flag;
    logic [V-1:0] vc;
    logic [Fpay-1:0] payload;
  } flit_t;
  typedef struct packed {
    flit_t flit;
    logic flit_wr;
    logic [V-1:0] credit;
    logic [CONGw-1:0] congestion;
  } flit_chanel_t;
  typedef struct packed {
    logic [PCK_INJ_Dw-1:0] data;
    logic [PCK_SIZw-1:0] size;
    logic [EAw-1:0] endp_addr;
    logic [Cw-1:0] class_num;
    logic [WEIGHTw-1:0] init_weight;
    logic [V-1:0] vc;
    logic pck_wr;
    logic [V-1:0] ready;
  } pck_injct_t;
  function automatic logic onehot(input logic [V-1:0] x);
    return (x != '0) && ((x & (x - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/inj_credit_counter.sv
// inj_credit_counter: per-VC downstream credit counters with a credit-available vector
module inj_credit_counter #(
  parameter int V = 4,
  parameter int CRDTw = 3,
  parameter int CREDIT_INIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [V-1:0] i_inc,
  input  logic [V-1:0] i_dec,
  output logic [V-1:0] o_nz
);
  localparam logic [CRDTw-1:0] INIT = CRDTw'(CREDIT_INIT);
  logic [CRDTw-1:0] r_cnt [V];
  logic [CRDTw-1:0] w_nxt [V];
  // a return and a send on the same VC cancel; returns past the initial value saturate
  always_comb begin
    for (int i = 0; i < V; i++) begin
      w_nxt[i] = (i_inc[i] && !i_dec[i]) ? ((r_cnt[i] == INIT) ? r_cnt[i] : r_cnt[i] + 1'b1) :
                 (i_dec[i] && !i_inc[i]) ? r_cnt[i] - 1'b1 : r_cnt[i];
      o_nz[i] = r_cnt[i] != '0;
    end
  end
  // counter registers, full credit after reset
  always_ff @(posedge clk or posedge reset) begin
    for (int i = 0; i < V; i++) r_cnt[i] <= reset ? INIT : w_nxt[i];
  end
  for (genvar v = 0; v < V; v++) begin : g_chk
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(i_inc[v] && !i_dec[v] && r_cnt[v] == INIT));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
      !(i_dec[v] && r_cnt[v] == '0));
  end
endmodule

// File: rtl/pck_flit_injector.sv
// pck_flit_injector: turns packet requests into header/body flits toward the router local port
module pck_flit_injector
  import pronoc_pkg::*;
#(
  parameter int CREDIT_INIT = B,
  parameter int MIN_PCK_SIZE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [EAw-1:0]   current_e_addr,
  input  pck_injct_t       pck_in,
  input  logic [DSTPw-1:0] dest_port_in,
  output logic [V-1:0]     pck_ready,
  output logic             pck_drop,
  input  flit_chanel_t     chan_in,
  output flit_chanel_t     chan_out
);
  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;
  state_t r_state, w_state_nxt;
  logic [V-1:0] r_vc, w_nz, w_dec;
  logic [PCK_INJ_Dw-1:0] r_rem;
  logic [PCK_SIZw-1:0] r_left, w_size;
  logic [Fpay-1:0] w_hdr;
  flit_t r_flit;
  logic r_flit_wr, r_drop, w_acc, w_body;
  logic w_unused;
  assign w_unused = ^{chan_in.flit, chan_in.flit_wr, chan_in.congestion, pck_in.ready};
  inj_credit_counter #(.V(V), .CRDTw(CRDTw), .CREDIT_INIT(CREDIT_INIT)) u_credit (
    .clk   (clk),
    .reset (reset),
    .i_inc (chan_in.credit),
    .i_dec (w_dec),
    .o_nz  (w_nz)
  );
  // header payload assembled straight from the request so it can be registered on acceptance
  always_comb begin
    w_hdr = '0;
    w_hdr[E_SRC_LSB +: EAw] = current_e_addr;
    w_hdr[E_DST_LSB +: EAw] = pck_in.endp_addr;
    w_hdr[DST_P_LSB +: DSTPw] = dest_port_in;
    if (C > 1) w_hdr[CLASS_LSB +: Cw] = pck_in.class_num;
    if (SWA_ARBITER_TYPE == "WRRA") w_hdr[WEIGHT_LSB +: WEIGHTw] = pck_in.init_weight;
    w_hdr[MSB_BE+1 +: HDR_MAX_DATw] = pck_in.data[HDR_MAX_DATw-1:0];
  end
  // acceptance, body-flit issue and credit consumption; the header itself is loaded on accept
  always_comb begin
    w_size = (pck_in.size < PCK_SIZw'(MIN_PCK_SIZE)) ? PCK_SIZw'(MIN_PCK_SIZE) : pck_in.size;
    pck_ready = (r_state == IDLE && !reset) ? w_nz : '0;
    w_acc = pck_in.pck_wr && onehot(pck_in.vc) && |(pck_in.vc & pck_ready);
    w_body = r_state != IDLE && r_left != '0 && |(r_vc & w_nz);
    w_dec = w_acc ? pck_in.vc : w_body ? r_vc : '0;
    chan_out = '0;
    chan_out.flit = r_flit;
    chan_out.flit_wr = r_flit_wr;
    pck_drop = r_drop;
  end
  // state follows the flit on the output register, so the tail cycle is never IDLE
  always_comb begin
    w_state_nxt = (r_state == IDLE) ? (w_acc ? HDR : IDLE) : (r_left == '0) ? IDLE : w_body ? BODY : r_state;
  end
  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  // output flit register and remaining-data shifter; stalls hold the pending slice
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vc <= '0;
      r_rem <= '0;
      r_left <= '0;
      r_flit <= '0;
      r_flit_wr <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= pck_in.pck_wr && !w_acc;
      r_flit_wr <= w_acc || w_body;
      if (w_acc) begin
        r_vc <= pck_in.vc;
        r_rem <= pck_in.data >> HDR_MAX_DATw;
        r_left <= w_size - 1'b1;
        r_flit <= '{hdr_flag: 1'b1, tail_flag: w_size == PCK_SIZw'(1), vc: pck_in.vc, payload: w_hdr};
      end else if (w_body) begin
        r_rem <= r_rem >> Fpay;
        r_left <= r_left - 1'b1;
        r_flit <= '{hdr_flag: 1'b0, tail_flag: r_left == PCK_SIZw'(1), vc: r_vc, payload: r_rem[Fpay-1:0]};
      end
    end
  end
endmodule

// File: tb/tb_pck_flit_injector.sv
// tb_pck_flit_injector: vector table plus corner sequences, flits checked against a scoreboard
module tb_pck_flit_injector;
  import pronoc_pkg::*;
  localparam logic [EAw-1:0] SRC = 6'd9;
  typedef struct {
    logic [7:0] size;
    logic [3:0] vc;
    logic [5:0] dest;
    logic [3:0] dstp;
    logic [1:0] cls;
    logic [3:0] wt;
    logic [63:0] data;
    int n;
  } vec_t;
  typedef struct {
    flit_t f;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  pck_injct_t pck_in = '0;
  logic [DSTPw-1:0] dest_port_in = '0;
  logic [V-1:0] pck_ready;
  logic pck_drop;
  flit_chanel_t chan_in = '0;
  flit_chanel_t chan_out;
  logic [3:0] man_cred = '0;
  logic auto_ret = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t q[$];
  vec_t tv[5];
  pck_flit_injector #(.CREDIT_INIT(2), .MIN_PCK_SIZE(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .current_e_addr (SRC),
    .pck_in         (pck_in),
    .dest_port_in   (dest_port_in),
    .pck_ready      (pck_ready),
    .pck_drop       (pck_drop),
    .chan_in        (chan_in),
    .chan_out       (chan_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic flit_t exp_flit(input vec_t r, input int k);
    flit_t f;
    f.hdr_flag = (k == 0);
    f.tail_flag = (k == r.n - 1);
    f.vc = r.vc;
    if (k == 0) f.payload = {r.data[9:0], r.wt, r.cls, r.dstp, r.dest, SRC};
    else f.payload = 32'(r.data >> (10 + 32 * (k - 1)));
    return f;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    chan_in.credit = man_cred | ((auto_ret && chan_out.flit_wr) ? chan_out.flit.vc : 4'b0);
    if (!reset && chan_out.flit_wr) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_flit got=%h at cycle %0d", chan_out.flit, cyc);
      end else begin
        e = q.pop_front();
        if (chan_out.flit !== e.f || (e.cyc >= 0 && cyc != e.cyc)) begin
          n_fail++;
          $display("FAIL flit got=%h at cycle %0d, want %h at cycle %0d", chan_out.flit, cyc, e.f, e.cyc);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask
  task automatic drive(input vec_t r, input logic wr);
    pck_in.data = r.data;
    pck_in.size = r.size;
    pck_in.endp_addr = r.dest;
    pck_in.class_num = r.cls;
    pck_in.init_weight = r.wt;
    pck_in.vc = r.vc;
    pck_in.pck_wr = wr;
    dest_port_in = r.dstp;
  endtask
  task automatic push_pkt(input vec_t r, input int t, input int known);
    exp_t e;
    for (int k = 0; k < r.n; k++) begin
      e.f = exp_flit(r, k);
      e.cyc = (k < known) ? t + 1 + k : -1;
      q.push_back(e);
    end
  endtask
  task automatic send(input vec_t r, input int known);
    drive(r, 1'b1);
    push_pkt(r, cyc, known);
    tick();
    pck_in.pck_wr = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask
  task automatic cred_pulse(input logic [3:0] v);
    man_cred = v;
    tick();
    man_cred = '0;
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t r;
    int t;
    tv[0] = '{size: 8'd1, vc: 4'b0001, dest: 6'd5, dstp: 4'd3, cls: 2'd1, wt: 4'd2, data: 64'hAB, n: 1};
    tv[1] = '{size: 8'd3, vc: 4'b0001, dest: 6'd7, dstp: 4'd1, cls: 2'd0, wt: 4'd1, data: 64'h0123_4567_89AB_CDEF, n: 3};
    tv[2] = '{size: 8'd0, vc: 4'b0100, dest: 6'd63, dstp: 4'd15, cls: 2'd3, wt: 4'd15, data: '1, n: 1};
    tv[3] = '{size: 8'd2, vc: 4'b1000, dest: 6'd0, dstp: 4'd0, cls: 2'd2, wt: 4'd0, data: 64'hFFFF_0000_1234_5678, n: 2};
    tv[4] = '{size: 8'd5, vc: 4'b0010, dest: 6'd33, dstp: 4'd9, cls: 2'd1, wt: 4'd8, data: 64'hDEAD_BEEF_CAFE_F00D, n: 5};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_chan_out", 64'(chan_out), 64'd0);
    chk("rst_ready", 64'(pck_ready), 64'd0);
    chk("rst_drop", 64'(pck_drop), 64'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    tick();
    chk("ready_after_rst", 64'(pck_ready), 64'hF);
    for (int i = 0; i < 5; i++) begin
      send(tv[i], tv[i].n);
      chk("accept_no_drop", 64'(pck_drop), 64'd0);
      chk("ready_busy", 64'(pck_ready), 64'd0);
      wait_done();
      tick();
      chk("ready_idle", 64'(pck_ready), 64'hF);
    end
    r = tv[0];
    r.vc = 4'b0010;
    send(r, 1);
    chk("b2b_ready_busy", 64'(pck_ready), 64'd0);
    tick();
    chk("b2b_gap_wr", 64'(chan_out.flit_wr), 64'd0);
    chk("b2b_gap_ready", 64'(pck_ready), 64'hF);
    r.vc = 4'b0100;
    send(r, 1);
    wait_done();
    tick();
    auto_ret = 1'b0;
    tick();
    send(tv[0], 1);
    wait_done();
    tick();
    chk("credit_one_left", 64'(pck_ready), 64'hF);
    send(tv[0], 1);
    wait_done();
    tick();
    chk("credit_zero_ready", 64'(pck_ready), 64'hE);
    drive(tv[0], 1'b1);
    tick();
    pck_in.pck_wr = 1'b0;
    chk("no_credit_drop", 64'(pck_drop), 64'd1);
    tick();
    chk("drop_one_cycle", 64'(pck_drop), 64'd0);
    cred_pulse(4'b0001);
    cred_pulse(4'b0001);
    chk("credit_restored", 64'(pck_ready), 64'hF);
    r = tv[4];
    r.size = 8'd4;
    r.n = 4;
    send(r, 2);
    repeat (6) tick();
    chk("stall_pending", 64'(q.size()), 64'd2);
    chk("stall_wr_low", 64'(chan_out.flit_wr), 64'd0);
    cred_pulse(4'b0010);
    repeat (3) tick();
    chk("stall_one_released", 64'(q.size()), 64'd1);
    chk("stall_wr_low2", 64'(chan_out.flit_wr), 64'd0);
    cred_pulse(4'b0010);
    repeat (3) tick();
    chk("stall_tail_released", 64'(q.size()), 64'd0);
    chk("stall_ready", 64'(pck_ready), 64'hD);
    cred_pulse(4'b0010);
    cred_pulse(4'b0010);
    chk("stall_restored", 64'(pck_ready), 64'hF);
    auto_ret = 1'b1;
    r = tv[4];
    r.vc = 4'b0001;
    send(r, 5);
    tick();
    drive(tv[2], 1'b1);
    tick();
    chk("drop_in_body", 64'(pck_drop), 64'd1);
    r = tv[2];
    r.vc = 4'b0011;
    drive(r, 1'b1);
    tick();
    chk("drop_multihot", 64'(pck_drop), 64'd1);
    r.vc = 4'b0000;
    drive(r, 1'b1);
    tick();
    chk("drop_zero_vc", 64'(pck_drop), 64'd1);
    pck_in.pck_wr = 1'b0;
    tick();
    chk("drop_cleared", 64'(pck_drop), 64'd0);
    wait_done();
    tick();
    r.vc = 4'b0011;
    drive(r, 1'b1);
    tick();
    pck_in.pck_wr = 1'b0;
    chk("idle_multihot_drop", 64'(pck_drop), 64'd1);
    tick();
    r = tv[4];
    r.vc = 4'b0001;
    r.size = 8'd4;
    r.n = 4;
    send(r, 4);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_wr", 64'(chan_out.flit_wr), 64'd0);
    chk("async_rst_ready", 64'(pck_ready), 64'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    auto_ret = 1'b0;
    tick();
    chk("post_rst_ready", 64'(pck_ready), 64'hF);
    r = tv[3];
    r.vc = 4'b0001;
    send(r, 2);
    wait_done();
    tick();
    chk("post_rst_credit", 64'(pck_ready), 64'hE);
    cred_pulse(4'b0001);
    cred_pulse(4'b0001);
    chk("final_ready", 64'(pck_ready), 64'hF);
    chk("final_queue", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
